// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI Mode 0 target emulating a serial NOR flash (READ, RDSR, RDID)
// backed by a synchronous byte memory; SPI pins are oversampled by clk.
module spi_flash_responder #(
   parameter int          ADDR_W   = 12,
   parameter logic [23:0] JEDEC_ID = 24'hEF4016,
   parameter logic [7:0]  STATUS   = 8'h00
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_SPI_CLK,
   input  logic              i_SPI_CS,
   input  logic              i_SPI_MOSI,
   output logic              o_SPI_MISO,
   output logic              o_SPI_MISO_OE,
   output logic              o_MEM_RD,
   output logic [ADDR_W-1:0] o_MEM_ADDR,
   input  logic [7:0]        i_MEM_DATA,
   output logic              o_BYTE_DONE
);
   localparam logic [2:0] S_IDLE = 3'd0, S_CMD = 3'd1, S_ADDR = 3'd2, S_DATA = 3'd3, S_IGN = 3'd4;
   localparam logic [1:0] M_READ = 2'd0, M_RDSR = 2'd1, M_RDID = 2'd2;
   logic [1:0]        sclk_s, cs_s, mosi_s;
   logic              sclk_d, cs_d;
   logic [2:0]        state;
   logic [1:0]        mode, id_idx;
   logic [5:0]        bitcnt;
   logic [2:0]        bcnt;
   logic [23:0]       sr;
   logic [7:0]        tx, nxt;
   logic              load, mem_lat;
   logic [ADDR_W-1:0] addr;
   logic              rise, fall, cs_hi;
   logic [23:0]       sr_in;
   logic [5:0]        bitcnt_inc;
   logic [7:0]        id_next;
   assign rise       = sclk_s[1] & ~sclk_d;
   assign fall       = ~sclk_s[1] & sclk_d;
   assign cs_hi      = cs_s[1];
   assign sr_in      = {sr[22:0], mosi_s[1]};
   assign bitcnt_inc = bitcnt + {5'd0, bitcnt != 6'd32};
   assign id_next    = id_idx == 2'd1 ? JEDEC_ID[15:8] : id_idx == 2'd2 ? JEDEC_ID[7:0] : 8'h00;
   assign o_MEM_ADDR = addr;
   // CS synchronizer resets low so a CS already held low at reset release is not taken as a new select
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sclk_s        <= '0;
         cs_s          <= '0;
         mosi_s        <= '0;
         sclk_d        <= 1'b0;
         cs_d          <= 1'b0;
         state         <= S_IDLE;
         mode          <= M_READ;
         id_idx        <= '0;
         bitcnt        <= '0;
         bcnt          <= '0;
         sr            <= '0;
         tx            <= '0;
         nxt           <= '0;
         load          <= 1'b0;
         mem_lat       <= 1'b0;
         addr          <= '0;
         o_SPI_MISO    <= 1'b0;
         o_SPI_MISO_OE <= 1'b0;
         o_MEM_RD      <= 1'b0;
         o_BYTE_DONE   <= 1'b0;
      end else begin
         sclk_s      <= {sclk_s[0], i_SPI_CLK};
         cs_s        <= {cs_s[0], i_SPI_CS};
         mosi_s      <= {mosi_s[0], i_SPI_MOSI};
         sclk_d      <= sclk_s[1];
         cs_d        <= cs_s[1];
         o_MEM_RD    <= 1'b0;
         o_BYTE_DONE <= 1'b0;
         mem_lat     <= o_MEM_RD;
         if (cs_hi) begin
            state         <= S_IDLE;
            o_SPI_MISO_OE <= 1'b0;
            o_SPI_MISO    <= 1'b0;
            bitcnt        <= '0;
            bcnt          <= '0;
            load          <= 1'b0;
            mem_lat       <= 1'b0;
         end else begin
            case (state)
               S_IDLE: if (cs_d) begin
                  state  <= S_CMD;
                  bitcnt <= '0;
               end
               S_CMD: if (rise) begin
                  sr     <= sr_in;
                  bitcnt <= bitcnt_inc;
                  if (bitcnt == 6'd7) begin
                     bcnt <= '0;
                     case (sr_in[7:0])
                        8'h03: begin
                           state <= S_ADDR;
                           mode  <= M_READ;
                        end
                        8'h05: begin
                           state <= S_DATA;
                           mode  <= M_RDSR;
                           nxt   <= STATUS;
                           load  <= 1'b1;
                        end
                        8'h9F: begin
                           state  <= S_DATA;
                           mode   <= M_RDID;
                           nxt    <= JEDEC_ID[23:16];
                           id_idx <= 2'd1;
                           load   <= 1'b1;
                        end
                        default: state <= S_IGN;
                     endcase
                  end
               end
               S_ADDR: if (rise) begin
                  sr     <= sr_in;
                  bitcnt <= bitcnt_inc;
                  if (bitcnt == 6'd31) begin
                     addr     <= sr_in[ADDR_W-1:0];
                     o_MEM_RD <= 1'b1;
                     state    <= S_DATA;
                  end
               end
               S_DATA: begin
                  if (fall) begin
                     o_SPI_MISO_OE <= 1'b1;
                     {o_SPI_MISO, tx} <= load ? {nxt, 1'b0} : {tx, 1'b0};
                     load <= 1'b0;
                  end
                  if (mem_lat) begin
                     nxt  <= i_MEM_DATA;
                     load <= 1'b1;
                  end
                  if (rise) begin
                     bcnt <= bcnt + 3'd1;
                     if (bcnt == 3'd7) begin
                        o_BYTE_DONE <= 1'b1;
                        if (mode == M_READ) begin
                           addr     <= addr + ADDR_W'(1);
                           o_MEM_RD <= 1'b1;
                        end else begin
                           nxt    <= mode == M_RDSR ? STATUS : id_next;
                           id_idx <= id_idx + {1'b0, id_idx != 2'd3};
                           load   <= 1'b1;
                        end
                     end
                  end
               end
               S_IGN: o_SPI_MISO_OE <= 1'b0;
               default: state <= S_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: directed table plus randomized SPI transactions checked
// against a flash-level reference model (memory array, ID bytes, status byte).
module tb_spi_flash_responder;
   localparam int HALF = 5;
   logic        clk = 1'b0, reset = 1'b1, sclk = 1'b0, cs = 1'b1, mosi = 1'b0;
   logic        miso, oe, mem_rd, byte_done;
   logic [11:0] mem_addr;
   logic [7:0]  mem_data = 8'h00;
   logic [7:0]  mem [4096];
   int          passed = 0, total = 0;
   int          rd_cnt, done_cnt, consec;
   bit          oe_seen, oe_early, in_hdr, rd_prev;
   logic [11:0] rd_q[$];

   typedef struct {
      logic [7:0]  cmd;
      logic [23:0] addr;
      int          nb;
      logic [31:0] data;
      int          rd;
      int          done;
      bit          oe;
   } vec_t;
   vec_t tbl[5];

   always #5 clk = ~clk;

   spi_flash_responder dut (
      .clk(clk), .reset(reset), .i_SPI_CLK(sclk), .i_SPI_CS(cs), .i_SPI_MOSI(mosi),
      .o_SPI_MISO(miso), .o_SPI_MISO_OE(oe), .o_MEM_RD(mem_rd), .o_MEM_ADDR(mem_addr),
      .i_MEM_DATA(mem_data), .o_BYTE_DONE(byte_done)
   );

   always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

   always @(negedge clk) begin
      if (mem_rd) begin
         rd_cnt++;
         rd_q.push_back(mem_addr);
         if (rd_prev) consec++;
      end
      rd_prev = mem_rd;
      if (byte_done) done_cnt++;
      if (oe) begin
         oe_seen = 1'b1;
         if (in_hdr) oe_early = 1'b1;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   task automatic clear();
      rd_cnt = 0; done_cnt = 0; consec = 0;
      oe_seen = 1'b0; oe_early = 1'b0; in_hdr = 1'b0;
      rd_q.delete();
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic spi_bit(input logic b, output logic r);
      sclk = 1'b0;
      mosi = b;
      tick(HALF);
      sclk = 1'b1;
      r = miso;
      tick(HALF);
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic r;
      for (int i = 7; i >= 0; i--) spi_bit(b[i], r);
   endtask

   task automatic xfer(input logic [7:0] c, input logic [23:0] a, input int nb, output logic [31:0] rx);
      logic r;
      clear();
      rx = '0;
      cs = 1'b0;
      tick(HALF);
      in_hdr = 1'b1;
      send_byte(c);
      if (c == 8'h03) begin
         send_byte(a[23:16]);
         send_byte(a[15:8]);
         send_byte(a[7:0]);
      end
      in_hdr = 1'b0;
      for (int k = 0; k < nb; k++)
         for (int i = 7; i >= 0; i--) begin
            spi_bit(1'b0, r);
            if (k < 4) rx[24 - 8 * k + i] = r;
         end
      sclk = 1'b0;
      tick(HALF);
      cs = 1'b1;
      tick(8);
   endtask

   // Flash-level view: READ streams the memory with wrap at 4 KiB, RDID walks the ID then zeros
   function automatic logic [7:0] exp_byte(input logic [7:0] c, input logic [23:0] a, input int k);
      logic [7:0] id [3];
      id = '{8'hEF, 8'h40, 8'h16};
      if (c == 8'h03) return mem[12'((int'(a) + k) % 4096)];
      if (c == 8'h05) return 8'h00;
      if (c == 8'h9F) return k < 3 ? id[k] : 8'h00;
      return 8'h00;
   endfunction

   task automatic check_xfer(input string name, input logic [23:0] a, input logic [31:0] rx,
                             input logic [31:0] exp_data, input int exp_rd, input int exp_done, input bit exp_oe);
      int bad;
      bad = 0;
      foreach (rd_q[i]) if (rd_q[i] !== 12'((int'(a) + i) % 4096)) bad++;
      check({name, "_data"}, rx, exp_data);
      check({name, "_mem_rd_count"}, 32'(rd_cnt), 32'(exp_rd));
      check({name, "_byte_done_count"}, 32'(done_cnt), 32'(exp_done));
      check({name, "_oe_seen"}, 32'(oe_seen), 32'(exp_oe));
      check({name, "_oe_early"}, 32'(oe_early), 32'd0);
      check({name, "_mem_rd_consecutive"}, 32'(consec), 32'd0);
      if (exp_rd > 0) check({name, "_rd_addr_seq"}, 32'(bad), 32'd0);
   endtask

   initial begin
      logic [31:0] rx, exp;
      logic [7:0]  c;
      logic [23:0] a;
      logic        r;
      int          nb;
      bit          valid;
      for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
      mem[12'h123] = 8'hA5;
      mem[12'hFFE] = 8'h11;
      mem[12'hFFF] = 8'h22;
      mem[12'h000] = 8'h33;
      mem[12'h010] = 8'h3C;
      tbl[0] = '{8'h03, 24'h000123, 1, 32'hA5000000, 2, 1, 1'b1};
      tbl[1] = '{8'h03, 24'h00FFFE, 3, 32'h11223300, 4, 3, 1'b1};
      tbl[2] = '{8'h9F, 24'h000000, 4, 32'hEF401600, 0, 4, 1'b1};
      tbl[3] = '{8'hAB, 24'h000000, 2, 32'h00000000, 0, 0, 1'b0};
      tbl[4] = '{8'h05, 24'h000000, 2, 32'h00000000, 0, 2, 1'b1};
      clear();
      tick(3);
      check("reset_outputs", {15'd0, miso, oe, mem_rd, byte_done, mem_addr}, 32'd0);
      reset = 1'b0;
      tick(4);

      for (int t = 0; t < 5; t++) begin
         xfer(tbl[t].cmd, tbl[t].addr, tbl[t].nb, rx);
         check_xfer($sformatf("vec%0d", t), tbl[t].addr, rx, tbl[t].data, tbl[t].rd, tbl[t].done, tbl[t].oe);
      end

      clear();
      cs = 1'b0;
      tick(HALF);
      send_byte(8'h03);
      send_byte(8'h00);
      for (int i = 0; i < 4; i++) spi_bit(1'b0, r);
      sclk = 1'b0;
      tick(HALF);
      cs = 1'b1;
      tick(8);
      check("abort_mem_rd_count", 32'(rd_cnt), 32'd0);
      check("abort_oe_miso", {30'd0, oe, miso}, 32'd0);
      xfer(8'h03, 24'h000010, 1, rx);
      check("after_abort_data", {24'd0, rx[31:24]}, 32'h3C);
      check("after_abort_first_rd", rd_q.size() > 0 ? 32'(rd_q[0]) : 32'hFFFFFFFF, 32'h010);

      clear();
      cs = 1'b0;
      tick(HALF);
      send_byte(8'h9F);
      for (int i = 0; i < 3; i++) spi_bit(1'b0, r);
      check("pre_reset_oe_miso", {30'd0, oe, miso}, 32'd3);
      #2 reset = 1'b1;
      #1 check("reset_mid_data", {29'd0, oe, miso, mem_rd}, 32'd0);
      sclk = 1'b0;
      cs = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(4);
      xfer(8'h05, 24'h000000, 1, rx);
      check_xfer("rdsr_after_reset", 24'h0, rx, 32'h00000000, 0, 1, 1'b1);

      for (int t = 0; t < 24; t++) begin
         case ($urandom_range(0, 3))
            0: c = 8'h03;
            1: c = 8'h05;
            2: c = 8'h9F;
            default: begin
               c = 8'($urandom);
               if (c == 8'h03 || c == 8'h05 || c == 8'h9F) c = 8'hAB;
            end
         endcase
         a = 24'($urandom);
         if ($urandom_range(0, 2) == 0) a[11:0] = 12'hFFD + 12'($urandom_range(0, 2));
         nb = $urandom_range(1, 4);
         valid = c == 8'h03 || c == 8'h05 || c == 8'h9F;
         exp = '0;
         for (int k = 0; k < nb; k++) exp[31 - 8 * k -: 8] = exp_byte(c, a, k);
         xfer(c, a, nb, rx);
         check_xfer($sformatf("rnd%0d_cmd%h", t, c), a, rx, exp,
                    c == 8'h03 ? nb + 1 : 0, valid ? nb : 0, valid);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
